// File: rtl/seg_scan_ctrl_if.sv
// Purpose: bundles the datapath-side digit load interface and the board-side
//          segment/digit pins of the 7-segment scan controller.
// Ports (signals):
//   din   4*NDIG  digit values, din[4i+3:4i] is digit i (i=0 is the LSD)
//   ld    1       load strobe
//   lzb   1       leading-zero blanking enable
//   seg   8       segment bus, active low, bit7 = dp (always 1)
//   dig   NDIG    digit enables, active low
//   frame 1       pulse on the last cycle of each frame
//   ack   1       pulse in the first cycle of a frame that took a new load
interface seg_scan_ctrl_if #(
  parameter int unsigned NDIG = 4
);
  logic [4*NDIG-1:0] din;
  logic              ld;
  logic              lzb;
  logic [7:0]        seg;
  logic [NDIG-1:0]   dig;
  logic              frame;
  logic              ack;

  // Datapath / driver side
  modport master (output din, ld, lzb, input seg, dig, frame, ack);
  // Scan controller side
  modport slave  (input din, ld, lzb, output seg, dig, frame, ack);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexed scan controller for a common-anode 7-segment
//          display. One digit is enabled per slot of DIV cycles; the first
//          BLANK cycles of each slot are dead time. New digit values are
//          double-buffered and only take effect at a frame boundary.
// Ports:
//   ck    clock, rising edge
//   rs    asynchronous reset, active low
//   bus   seg_scan_ctrl_if.slave (din/ld/lzb in, seg/dig/frame/ack out)
module seg_scan_ctrl #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic            ck,
  input  logic            rs,
  seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned DW = 4 * NDIG;
  localparam int unsigned CW = $clog2(DIV);
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]   r_cnt,    w_cnt_n;
  logic [IW-1:0]   r_idx,    w_idx_n;
  logic [DW-1:0]   r_shadow, w_shadow_n;
  logic [DW-1:0]   r_pbuf,   w_pbuf_n;
  logic            r_pend,   w_pend_n;
  logic [7:0]      r_seg,    w_seg_n;
  logic [NDIG-1:0] r_dig,    w_dig_n;
  logic            r_frame,  w_frame_n;
  logic            r_ack,    w_ack_n;

  logic            w_boundary;
  logic            w_upper_nz;
  logic            w_suppress;
  logic            w_drive;
  logic [3:0]      w_digit;

  // Active-low segment pattern for one hex digit (dp off)
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'h0: seg_code = 8'hC0;
      4'h1: seg_code = 8'hF9;
      4'h2: seg_code = 8'hA4;
      4'h3: seg_code = 8'hB0;
      4'h4: seg_code = 8'h99;
      4'h5: seg_code = 8'h92;
      4'h6: seg_code = 8'h82;
      4'h7: seg_code = 8'hF8;
      4'h8: seg_code = 8'h80;
      4'h9: seg_code = 8'h90;
      4'hA: seg_code = 8'h88;
      4'hB: seg_code = 8'h83;
      4'hC: seg_code = 8'hC6;
      4'hD: seg_code = 8'hA1;
      4'hE: seg_code = 8'h86;
      4'hF: seg_code = 8'h8E;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Next-state and next-output logic. Outputs are computed from the
  // next cnt/idx/shadow so the registered pins line up with the scan position.
  always_comb begin
    w_cnt_n    = r_cnt + CW'(1);
    w_idx_n    = r_idx;
    w_shadow_n = r_shadow;
    w_pbuf_n   = r_pbuf;
    w_pend_n   = r_pend;
    w_ack_n    = 1'b0;
    w_seg_n    = 8'hFF;
    w_dig_n    = '1;
    w_digit    = 4'h0;
    w_upper_nz = 1'b0;

    w_boundary = (r_idx == IW'(NDIG - 1)) && (r_cnt == CW'(DIV - 1));

    if (r_cnt == CW'(DIV - 1)) begin
      w_cnt_n = '0;
      w_idx_n = (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + IW'(1);
    end

    // Pending buffer: last load before the boundary wins
    if (bus.ld) begin
      w_pbuf_n = bus.din;
      w_pend_n = 1'b1;
    end

    // A load in the boundary cycle itself goes straight to the shadow
    if (w_boundary) begin
      if (r_pend || bus.ld) begin
        w_shadow_n = bus.ld ? bus.din : r_pbuf;
        w_ack_n    = 1'b1;
      end
      w_pend_n = 1'b0;
    end

    // Digit value for the upcoming slot, and whether it or anything above is non-zero
    for (int j = 0; j < int'(NDIG); j++) begin
      if (IW'(j) == w_idx_n) begin
        w_digit = w_shadow_n[4*j +: 4];
      end
      if ((j >= int'(w_idx_n)) && (w_shadow_n[4*j +: 4] != 4'h0)) begin
        w_upper_nz = 1'b1;
      end
    end

    w_suppress = bus.lzb && (w_idx_n != '0) && !w_upper_nz;
    w_drive    = (w_cnt_n >= CW'(BLANK)) && !w_suppress;

    if (w_drive) begin
      w_seg_n = seg_code(w_digit);
      for (int j = 0; j < int'(NDIG); j++) begin
        if (IW'(j) == w_idx_n) begin
          w_dig_n[j] = 1'b0;
        end
      end
    end

    w_frame_n = (w_idx_n == IW'(NDIG - 1)) && (w_cnt_n == CW'(DIV - 1));
  end

  // State and output registers
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_pbuf   <= '0;
      r_pend   <= 1'b0;
      r_seg    <= 8'hFF;
      r_dig    <= '1;
      r_frame  <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_n;
      r_idx    <= w_idx_n;
      r_shadow <= w_shadow_n;
      r_pbuf   <= w_pbuf_n;
      r_pend   <= w_pend_n;
      r_seg    <= w_seg_n;
      r_dig    <= w_dig_n;
      r_frame  <= w_frame_n;
      r_ack    <= w_ack_n;
    end
  end

  assign bus.seg   = r_seg;
  assign bus.dig   = r_dig;
  assign bus.frame = r_frame;
  assign bus.ack   = r_ack;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Purpose: self-checking bench for seg_scan_ctrl (NDIG=4, DIV=4, BLANK=1).
// Expected per-cycle outputs are queued when a frame's stimulus is driven and
// popped by a negedge monitor as the DUT produces them.
module tb_seg_scan_ctrl;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIV   = 4;
  localparam int unsigned BLANK = 1;
  localparam int          FRAME = NDIG * DIV;

  logic ck = 1'b0;
  logic rs = 1'b0;
  always #5 ck = ~ck;

  seg_scan_ctrl_if #(.NDIG(NDIG)) bus ();

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) u_dut (
    .ck  (ck),
    .rs  (rs),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [3:0] dig;
    logic       frm;
    logic       ack;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   mon_cyc = 0;
  int   base    = 0;
  bit   mon_en  = 1'b0;

  function automatic logic [7:0] ref_code(input logic [3:0] d);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[d];
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge ck) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == mon_cyc) begin
        mon_e = q.pop_front();
        check($sformatf("seg@%0d", mon_cyc),   32'(bus.seg),   32'(mon_e.seg));
        check($sformatf("dig@%0d", mon_cyc),   32'(bus.dig),   32'(mon_e.dig));
        check($sformatf("frame@%0d", mon_cyc), 32'(bus.frame), 32'(mon_e.frm));
        check($sformatf("ack@%0d", mon_cyc),   32'(bus.ack),   32'(mon_e.ack));
      end
      mon_cyc++;
    end
  end

  // Queue the expected outputs of one frame (sh = shadow in effect) and drive it.
  // Called at the start of cycle 0 of the frame; ldk_* = -1 means no load.
  task automatic run_frame(input logic [15:0] sh, input bit lz, input bit ack_e,
                           input int ldk_a, input logic [15:0] din_a,
                           input int ldk_b, input logic [15:0] din_b,
                           input int ncyc);
    exp_t e;
    int   c;
    int   i;
    bit   sup;
    for (int k = 0; k < ncyc; k++) begin
      c     = k % DIV;
      i     = k / DIV;
      sup   = lz && (i > 0) && ((sh >> (4 * i)) == 16'h0);
      e.cyc = base + k;
      e.frm = (k == FRAME - 1);
      e.ack = ack_e && (k == 0);
      if (c < int'(BLANK) || sup) begin
        e.seg = 8'hFF;
        e.dig = 4'hF;
      end else begin
        e.seg = ref_code(sh[4*i +: 4]);
        e.dig = 4'(~(4'b0001 << i));
      end
      q.push_back(e);
    end
    for (int k = 0; k < ncyc; k++) begin
      bus.lzb = lz;
      bus.ld  = (k == ldk_a) || (k == ldk_b);
      if (k == ldk_b)      bus.din = din_b;
      else if (k == ldk_a) bus.din = din_a;
      else                 bus.din = 16'($urandom);
      @(posedge ck);
      #2;
    end
    bus.ld = 1'b0;
    base  += ncyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.ld  = 1'b0;
    bus.din = 16'h0;
    bus.lzb = 1'b0;
    rs      = 1'b0;
    repeat (3) @(posedge ck);
    #2;
    check("rst_seg",   32'(bus.seg),   32'h0000_00FF);
    check("rst_dig",   32'(bus.dig),   32'h0000_000F);
    check("rst_frame", 32'(bus.frame), 32'h0);
    check("rst_ack",   32'(bus.ack),   32'h0);
    rs     = 1'b1;
    mon_en = 1'b1;

    // Post-reset scan of all-zero shadow
    run_frame(16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    // Single mid-frame load, shown next frame with ack
    run_frame(16'h0000, 1'b0, 1'b0,  6, 16'h1234, -1, 16'h0, FRAME);
    run_frame(16'h1234, 1'b0, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
    // Leading-zero blanking, then disabled again
    run_frame(16'h1234, 1'b0, 1'b0,  3, 16'h0070, -1, 16'h0, FRAME);
    run_frame(16'h0070, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
    // Two loads in one frame: last wins, single ack
    run_frame(16'h0070, 1'b0, 1'b0,  2, 16'h1111, 10, 16'h2222, FRAME);
    // Load exactly in the boundary cycle
    run_frame(16'h2222, 1'b0, 1'b1, 15, 16'hABCD, -1, 16'h0, FRAME);
    run_frame(16'hABCD, 1'b0, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
    // Load pending, then reset in the middle of slot 2
    run_frame(16'hABCD, 1'b0, 1'b0,  2, 16'h9999, -1, 16'h0, 9);

    mon_en = 1'b0;
    rs     = 1'b0;
    #1;
    check("mid_rst_seg", 32'(bus.seg),   32'h0000_00FF);
    check("mid_rst_dig", 32'(bus.dig),   32'h0000_000F);
    check("mid_rst_ack", 32'(bus.ack),   32'h0);
    check("mid_rst_frm", 32'(bus.frame), 32'h0);
    @(posedge ck);
    #2;
    check("mid_rst_q", 32'(q.size()), 32'h0);
    q.delete();
    rs      = 1'b1;
    mon_cyc = 0;
    base    = 0;
    mon_en  = 1'b1;

    // Shadow cleared, pending load discarded, no ack
    run_frame(16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
    run_frame(16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);

    check("q_drain", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
